// File: rtl/inv_sub_bytes_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// inv_sub_bytes_iter : iterative AES InvSubBytes, BYTES_PER_CYCLE lanes/cycle
// Revision: 1.0
// ============================================================================
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int ITER    = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int GROUP_W = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  generate
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
      $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_fsm;
  state_t               w_fsm_nxt;
  logic [127:0]         r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [GROUP_W-1:0]   w_group;
  logic [GROUP_W-1:0]   w_group_sub;
  logic                 w_accept;
  logic                 w_last;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    inv_sbox = 8'h00;
    case (x)
      8'h00: inv_sbox = 8'h52;
      8'h01: inv_sbox = 8'h09;
      8'h02: inv_sbox = 8'h6a;
      8'h03: inv_sbox = 8'hd5;
      8'h04: inv_sbox = 8'h30;
      8'h05: inv_sbox = 8'h36;
      8'h06: inv_sbox = 8'ha5;
      8'h07: inv_sbox = 8'h38;
      8'h08: inv_sbox = 8'hbf;
      8'h09: inv_sbox = 8'h40;
      8'h0a: inv_sbox = 8'ha3;
      8'h0b: inv_sbox = 8'h9e;
      8'h0c: inv_sbox = 8'h81;
      8'h0d: inv_sbox = 8'hf3;
      8'h0e: inv_sbox = 8'hd7;
      8'h0f: inv_sbox = 8'hfb;
      8'h10: inv_sbox = 8'h7c;
      8'h11: inv_sbox = 8'he3;
      8'h12: inv_sbox = 8'h39;
      8'h13: inv_sbox = 8'h82;
      8'h14: inv_sbox = 8'h9b;
      8'h15: inv_sbox = 8'h2f;
      8'h16: inv_sbox = 8'hff;
      8'h17: inv_sbox = 8'h87;
      8'h18: inv_sbox = 8'h34;
      8'h19: inv_sbox = 8'h8e;
      8'h1a: inv_sbox = 8'h43;
      8'h1b: inv_sbox = 8'h44;
      8'h1c: inv_sbox = 8'hc4;
      8'h1d: inv_sbox = 8'hde;
      8'h1e: inv_sbox = 8'he9;
      8'h1f: inv_sbox = 8'hcb;
      8'h20: inv_sbox = 8'h54;
      8'h21: inv_sbox = 8'h7b;
      8'h22: inv_sbox = 8'h94;
      8'h23: inv_sbox = 8'h32;
      8'h24: inv_sbox = 8'ha6;
      8'h25: inv_sbox = 8'hc2;
      8'h26: inv_sbox = 8'h23;
      8'h27: inv_sbox = 8'h3d;
      8'h28: inv_sbox = 8'hee;
      8'h29: inv_sbox = 8'h4c;
      8'h2a: inv_sbox = 8'h95;
      8'h2b: inv_sbox = 8'h0b;
      8'h2c: inv_sbox = 8'h42;
      8'h2d: inv_sbox = 8'hfa;
      8'h2e: inv_sbox = 8'hc3;
      8'h2f: inv_sbox = 8'h4e;
      8'h30: inv_sbox = 8'h08;
      8'h31: inv_sbox = 8'h2e;
      8'h32: inv_sbox = 8'ha1;
      8'h33: inv_sbox = 8'h66;
      8'h34: inv_sbox = 8'h28;
      8'h35: inv_sbox = 8'hd9;
      8'h36: inv_sbox = 8'h24;
      8'h37: inv_sbox = 8'hb2;
      8'h38: inv_sbox = 8'h76;
      8'h39: inv_sbox = 8'h5b;
      8'h3a: inv_sbox = 8'ha2;
      8'h3b: inv_sbox = 8'h49;
      8'h3c: inv_sbox = 8'h6d;
      8'h3d: inv_sbox = 8'h8b;
      8'h3e: inv_sbox = 8'hd1;
      8'h3f: inv_sbox = 8'h25;
      8'h40: inv_sbox = 8'h72;
      8'h41: inv_sbox = 8'hf8;
      8'h42: inv_sbox = 8'hf6;
      8'h43: inv_sbox = 8'h64;
      8'h44: inv_sbox = 8'h86;
      8'h45: inv_sbox = 8'h68;
      8'h46: inv_sbox = 8'h98;
      8'h47: inv_sbox = 8'h16;
      8'h48: inv_sbox = 8'hd4;
      8'h49: inv_sbox = 8'ha4;
      8'h4a: inv_sbox = 8'h5c;
      8'h4b: inv_sbox = 8'hcc;
      8'h4c: inv_sbox = 8'h5d;
      8'h4d: inv_sbox = 8'h65;
      8'h4e: inv_sbox = 8'hb6;
      8'h4f: inv_sbox = 8'h92;
      8'h50: inv_sbox = 8'h6c;
      8'h51: inv_sbox = 8'h70;
      8'h52: inv_sbox = 8'h48;
      8'h53: inv_sbox = 8'h50;
      8'h54: inv_sbox = 8'hfd;
      8'h55: inv_sbox = 8'hed;
      8'h56: inv_sbox = 8'hb9;
      8'h57: inv_sbox = 8'hda;
      8'h58: inv_sbox = 8'h5e;
      8'h59: inv_sbox = 8'h15;
      8'h5a: inv_sbox = 8'h46;
      8'h5b: inv_sbox = 8'h57;
      8'h5c: inv_sbox = 8'ha7;
      8'h5d: inv_sbox = 8'h8d;
      8'h5e: inv_sbox = 8'h9d;
      8'h5f: inv_sbox = 8'h84;
      8'h60: inv_sbox = 8'h90;
      8'h61: inv_sbox = 8'hd8;
      8'h62: inv_sbox = 8'hab;
      8'h63: inv_sbox = 8'h00;
      8'h64: inv_sbox = 8'h8c;
      8'h65: inv_sbox = 8'hbc;
      8'h66: inv_sbox = 8'hd3;
      8'h67: inv_sbox = 8'h0a;
      8'h68: inv_sbox = 8'hf7;
      8'h69: inv_sbox = 8'he4;
      8'h6a: inv_sbox = 8'h58;
      8'h6b: inv_sbox = 8'h05;
      8'h6c: inv_sbox = 8'hb8;
      8'h6d: inv_sbox = 8'hb3;
      8'h6e: inv_sbox = 8'h45;
      8'h6f: inv_sbox = 8'h06;
      8'h70: inv_sbox = 8'hd0;
      8'h71: inv_sbox = 8'h2c;
      8'h72: inv_sbox = 8'h1e;
      8'h73: inv_sbox = 8'h8f;
      8'h74: inv_sbox = 8'hca;
      8'h75: inv_sbox = 8'h3f;
      8'h76: inv_sbox = 8'h0f;
      8'h77: inv_sbox = 8'h02;
      8'h78: inv_sbox = 8'hc1;
      8'h79: inv_sbox = 8'haf;
      8'h7a: inv_sbox = 8'hbd;
      8'h7b: inv_sbox = 8'h03;
      8'h7c: inv_sbox = 8'h01;
      8'h7d: inv_sbox = 8'h13;
      8'h7e: inv_sbox = 8'h8a;
      8'h7f: inv_sbox = 8'h6b;
      8'h80: inv_sbox = 8'h3a;
      8'h81: inv_sbox = 8'h91;
      8'h82: inv_sbox = 8'h11;
      8'h83: inv_sbox = 8'h41;
      8'h84: inv_sbox = 8'h4f;
      8'h85: inv_sbox = 8'h67;
      8'h86: inv_sbox = 8'hdc;
      8'h87: inv_sbox = 8'hea;
      8'h88: inv_sbox = 8'h97;
      8'h89: inv_sbox = 8'hf2;
      8'h8a: inv_sbox = 8'hcf;
      8'h8b: inv_sbox = 8'hce;
      8'h8c: inv_sbox = 8'hf0;
      8'h8d: inv_sbox = 8'hb4;
      8'h8e: inv_sbox = 8'he6;
      8'h8f: inv_sbox = 8'h73;
      8'h90: inv_sbox = 8'h96;
      8'h91: inv_sbox = 8'hac;
      8'h92: inv_sbox = 8'h74;
      8'h93: inv_sbox = 8'h22;
      8'h94: inv_sbox = 8'he7;
      8'h95: inv_sbox = 8'had;
      8'h96: inv_sbox = 8'h35;
      8'h97: inv_sbox = 8'h85;
      8'h98: inv_sbox = 8'he2;
      8'h99: inv_sbox = 8'hf9;
      8'h9a: inv_sbox = 8'h37;
      8'h9b: inv_sbox = 8'he8;
      8'h9c: inv_sbox = 8'h1c;
      8'h9d: inv_sbox = 8'h75;
      8'h9e: inv_sbox = 8'hdf;
      8'h9f: inv_sbox = 8'h6e;
      8'ha0: inv_sbox = 8'h47;
      8'ha1: inv_sbox = 8'hf1;
      8'ha2: inv_sbox = 8'h1a;
      8'ha3: inv_sbox = 8'h71;
      8'ha4: inv_sbox = 8'h1d;
      8'ha5: inv_sbox = 8'h29;
      8'ha6: inv_sbox = 8'hc5;
      8'ha7: inv_sbox = 8'h89;
      8'ha8: inv_sbox = 8'h6f;
      8'ha9: inv_sbox = 8'hb7;
      8'haa: inv_sbox = 8'h62;
      8'hab: inv_sbox = 8'h0e;
      8'hac: inv_sbox = 8'haa;
      8'had: inv_sbox = 8'h18;
      8'hae: inv_sbox = 8'hbe;
      8'haf: inv_sbox = 8'h1b;
      8'hb0: inv_sbox = 8'hfc;
      8'hb1: inv_sbox = 8'h56;
      8'hb2: inv_sbox = 8'h3e;
      8'hb3: inv_sbox = 8'h4b;
      8'hb4: inv_sbox = 8'hc6;
      8'hb5: inv_sbox = 8'hd2;
      8'hb6: inv_sbox = 8'h79;
      8'hb7: inv_sbox = 8'h20;
      8'hb8: inv_sbox = 8'h9a;
      8'hb9: inv_sbox = 8'hdb;
      8'hba: inv_sbox = 8'hc0;
      8'hbb: inv_sbox = 8'hfe;
      8'hbc: inv_sbox = 8'h78;
      8'hbd: inv_sbox = 8'hcd;
      8'hbe: inv_sbox = 8'h5a;
      8'hbf: inv_sbox = 8'hf4;
      8'hc0: inv_sbox = 8'h1f;
      8'hc1: inv_sbox = 8'hdd;
      8'hc2: inv_sbox = 8'ha8;
      8'hc3: inv_sbox = 8'h33;
      8'hc4: inv_sbox = 8'h88;
      8'hc5: inv_sbox = 8'h07;
      8'hc6: inv_sbox = 8'hc7;
      8'hc7: inv_sbox = 8'h31;
      8'hc8: inv_sbox = 8'hb1;
      8'hc9: inv_sbox = 8'h12;
      8'hca: inv_sbox = 8'h10;
      8'hcb: inv_sbox = 8'h59;
      8'hcc: inv_sbox = 8'h27;
      8'hcd: inv_sbox = 8'h80;
      8'hce: inv_sbox = 8'hec;
      8'hcf: inv_sbox = 8'h5f;
      8'hd0: inv_sbox = 8'h60;
      8'hd1: inv_sbox = 8'h51;
      8'hd2: inv_sbox = 8'h7f;
      8'hd3: inv_sbox = 8'ha9;
      8'hd4: inv_sbox = 8'h19;
      8'hd5: inv_sbox = 8'hb5;
      8'hd6: inv_sbox = 8'h4a;
      8'hd7: inv_sbox = 8'h0d;
      8'hd8: inv_sbox = 8'h2d;
      8'hd9: inv_sbox = 8'he5;
      8'hda: inv_sbox = 8'h7a;
      8'hdb: inv_sbox = 8'h9f;
      8'hdc: inv_sbox = 8'h93;
      8'hdd: inv_sbox = 8'hc9;
      8'hde: inv_sbox = 8'h9c;
      8'hdf: inv_sbox = 8'hef;
      8'he0: inv_sbox = 8'ha0;
      8'he1: inv_sbox = 8'he0;
      8'he2: inv_sbox = 8'h3b;
      8'he3: inv_sbox = 8'h4d;
      8'he4: inv_sbox = 8'hae;
      8'he5: inv_sbox = 8'h2a;
      8'he6: inv_sbox = 8'hf5;
      8'he7: inv_sbox = 8'hb0;
      8'he8: inv_sbox = 8'hc8;
      8'he9: inv_sbox = 8'heb;
      8'hea: inv_sbox = 8'hbb;
      8'heb: inv_sbox = 8'h3c;
      8'hec: inv_sbox = 8'h83;
      8'hed: inv_sbox = 8'h53;
      8'hee: inv_sbox = 8'h99;
      8'hef: inv_sbox = 8'h61;
      8'hf0: inv_sbox = 8'h17;
      8'hf1: inv_sbox = 8'h2b;
      8'hf2: inv_sbox = 8'h04;
      8'hf3: inv_sbox = 8'h7e;
      8'hf4: inv_sbox = 8'hba;
      8'hf5: inv_sbox = 8'h77;
      8'hf6: inv_sbox = 8'hd6;
      8'hf7: inv_sbox = 8'h26;
      8'hf8: inv_sbox = 8'he1;
      8'hf9: inv_sbox = 8'h69;
      8'hfa: inv_sbox = 8'h14;
      8'hfb: inv_sbox = 8'h63;
      8'hfc: inv_sbox = 8'h55;
      8'hfd: inv_sbox = 8'h21;
      8'hfe: inv_sbox = 8'h0c;
      8'hff: inv_sbox = 8'h7d;
    endcase
  endfunction

  assign w_accept  = (r_fsm == IDLE) && in_valid;
  assign w_last    = (r_cnt == CNT_LAST);
  assign out_state = r_state;

  // Group selected by the counter feeds the shared lookup lanes.
  always_comb begin
    w_group = '0;
    for (int g = 0; g < ITER; g++) begin
      if (r_cnt == CNT_W'(g)) begin
        w_group = r_state[g*GROUP_W +: GROUP_W];
      end
    end
  end

  generate
    for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lane
      assign w_group_sub[i*8 +: 8] = inv_sbox(w_group[i*8 +: 8]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (w_last) w_fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // State register only moves on capture or while substituting, so DONE holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= in_state;
      r_cnt   <= '0;
    end else if (r_fsm == SUB) begin
      for (int g = 0; g < ITER; g++) begin
        if (r_cnt == CNT_W'(g)) begin
          r_state[g*GROUP_W +: GROUP_W] <= w_group_sub;
        end
      end
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for inv_sub_bytes_iter: directed table, handshake corner cases,
// and per-width sweeps against an S-box model derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   inv_tab [256];
  logic         tab_ready = 1'b0;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[s[i*8 +: 8]];
    return r;
  endfunction

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
    tab_ready = 1'b1;
  end

  // Called at #1 after an edge with the DUT idle; returns at #1 after the
  // edge that raised out_valid (or after the cycle budget ran out).
  task automatic do_block(input logic [127:0] s, output logic [127:0] res,
                          output int lat, output int nbusy);
    in_state = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    res = out_state;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SB   = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    localparam int SLAT = 16 / SB;
    logic         s_rst_n     = 1'b0;
    logic         s_in_valid  = 1'b0;
    logic         s_out_ready = 1'b1;
    logic         s_in_ready;
    logic         s_out_valid;
    logic         s_busy;
    logic [127:0] s_in_state  = '0;
    logic [127:0] s_out_state;
    logic         done        = 1'b0;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(SB)) u_dut (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_state  (s_in_state),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_state (s_out_state),
      .busy      (s_busy)
    );

    initial begin
      logic [127:0] st;
      int           lat;
      wait (tab_ready);
      repeat (2) @(posedge clk);
      #1 s_rst_n = 1'b1;
      for (int n = 0; n < 200; n++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        s_in_state = st;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (s_out_valid !== 1'b1 && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        check_val($sformatf("sweep_b%0d_data_%0d", SB, n), s_out_state, ref_inv(st));
        check_val($sformatf("sweep_b%0d_lat_%0d", SB, n), 128'(lat), 128'(SLAT));
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    vec_t         vecs [6];
    logic [127:0] res;
    logic [127:0] bq [10];
    int           acc_cyc [10];
    int           lat, nb, idx, nout, cyc;
    logic         ok, acc, all_done;

    vecs[0] = '{128'h0, {16{8'h52}}};
    vecs[1] = '{{4{32'h000163ff}}, {4{32'h5209007d}}};
    vecs[2] = '{{16{8'h53}}, {16{8'h50}}};
    vecs[3] = '{{16{8'hff}}, {16{8'h7d}}};
    vecs[4] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[5] = '{{16{8'h63}}, 128'h0};

    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    wait (tab_ready);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 128'(out_valid), 128'(0));
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_out_state", out_state, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_in_ready", 128'(in_ready), 128'(1));

    // Directed table, no backpressure
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      do_block(vecs[v].din, res, lat, nb);
      check_val($sformatf("vec%0d_data", v), res, vecs[v].dout);
      check_val($sformatf("vec%0d_lat", v), 128'(lat), 128'(4));
      check_val($sformatf("vec%0d_busy_cycles", v), 128'(nb), 128'(4));
      @(posedge clk); #1;
      check_val($sformatf("vec%0d_idle_ready", v), 128'({in_ready, out_valid}), 128'(2'b10));
    end

    // Backpressure with an intruding in_valid pulse
    out_ready = 1'b0;
    do_block(vecs[1].din, res, lat, nb);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin in_valid = 1'b1; in_state = {16{8'haa}}; end
      if (c == 7) in_valid = 1'b0;
      if (out_state !== vecs[1].dout || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
    end
    check_val("stall_stable", 128'(ok), 128'(1));
    check_val("stall_data", out_state, vecs[1].dout);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("stall_release_idle", 128'({in_ready, out_valid}), 128'(2'b10));
    do_block(vecs[4].din, res, lat, nb);
    check_val("after_stall_data", res, vecs[4].dout);
    @(posedge clk); #1;

    // Asynchronous reset after two of four SUB cycles
    in_state = vecs[3].din; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("midop_busy_before", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_val("midop_rst_flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    check_val("midop_rst_state", out_state, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_block(vecs[2].din, res, lat, nb);
    check_val("post_rst_data", res, vecs[2].dout);
    check_val("post_rst_lat", 128'(lat), 128'(4));
    @(posedge clk); #1;

    // Back-to-back traffic
    for (int i = 0; i < 10; i++) bq[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; nout = 0; cyc = 0;
    in_state = bq[0]; in_valid = 1'b1;
    while (nout < 10 && cyc < 300) begin
      acc = in_ready & in_valid;
      if (out_valid === 1'b1) begin
        check_val($sformatf("b2b_out%0d", nout), out_state, ref_inv(bq[nout]));
        nout++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 10) in_state = bq[idx];
        else in_valid = 1'b0;
      end
    end
    check_val("b2b_out_count", 128'(nout), 128'(10));
    check_val("b2b_acc_count", 128'(idx), 128'(10));
    ok = 1'b1;
    for (int i = 1; i < 10; i++) if (acc_cyc[i] - acc_cyc[i-1] != 6) ok = 1'b0;
    check_val("b2b_spacing", 128'(ok), 128'(1));
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check_val("b2b_no_extra", 128'(ok), 128'(1));

    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      all_done = g_sweep[0].done & g_sweep[1].done & g_sweep[2].done & g_sweep[3].done;
      if (!all_done) @(posedge clk);
    end
    check_val("sweeps_done", 128'(all_done), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
